// File: rtl/ex_div.sv
// ex_div: 32-bit restoring radix-2 divider for DIV/DIVU in the execute stage.
// result_o = {remainder, quotient}; one quotient bit is produced per cycle.
module ex_div (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  typedef enum logic [1:0] {
    S_FREE   = 2'd0,
    S_BYZERO = 2'd1,
    S_ON     = 2'd2,
    S_END    = 2'd3
  } state_e;

  state_e      state_q;
  logic [5:0]  cnt_q;
  logic [31:0] quo_q;
  logic [31:0] dvs_q;
  logic [31:0] rem_q;
  logic        negQuo_q;
  logic        negRem_q;
  logic [63:0] result_q;
  logic        ready_q;

  logic [31:0] absDividend_d;
  logic [31:0] absDivisor_d;
  logic [32:0] shifted_d;
  logic [32:0] trial_d;
  logic [31:0] remNext_d;
  logic [31:0] quoNext_d;
  logic [31:0] remFix_d;
  logic [31:0] quoFix_d;

  assign result_o = result_q;
  assign ready_o  = ready_q;

  // Operand magnitudes for the signed case, plus one restoring step and the final sign fix.
  always_comb begin
    absDividend_d = opdata1_i;
    absDivisor_d  = opdata2_i;
    if (signed_div_i && opdata1_i[31]) absDividend_d = ~opdata1_i + 32'd1;
    if (signed_div_i && opdata2_i[31]) absDivisor_d  = ~opdata2_i + 32'd1;

    shifted_d = {rem_q, quo_q[31]};
    trial_d   = shifted_d - {1'b0, dvs_q};
    if (!trial_d[32]) begin
      remNext_d = trial_d[31:0];
      quoNext_d = {quo_q[30:0], 1'b1};
    end else begin
      remNext_d = shifted_d[31:0];
      quoNext_d = {quo_q[30:0], 1'b0};
    end

    quoFix_d = negQuo_q ? (~quoNext_d + 32'd1) : quoNext_d;
    remFix_d = negRem_q ? (~remNext_d + 32'd1) : remNext_d;
  end

  // Control FSM and datapath registers; annul beats everything except reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_FREE;
      cnt_q    <= 6'd0;
      quo_q    <= 32'd0;
      dvs_q    <= 32'd0;
      rem_q    <= 32'd0;
      negQuo_q <= 1'b0;
      negRem_q <= 1'b0;
      result_q <= 64'd0;
      ready_q  <= 1'b0;
    end else if (annul_i) begin
      state_q  <= S_FREE;
      cnt_q    <= 6'd0;
      result_q <= 64'd0;
      ready_q  <= 1'b0;
    end else begin
      case (state_q)
        S_FREE: begin
          if (start_i) begin
            cnt_q <= 6'd0;
            if (opdata2_i == 32'd0) begin
              state_q <= S_BYZERO;
            end else begin
              state_q  <= S_ON;
              quo_q    <= absDividend_d;
              dvs_q    <= absDivisor_d;
              rem_q    <= 32'd0;
              negQuo_q <= signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
              negRem_q <= signed_div_i & opdata1_i[31];
            end
          end
        end
        S_BYZERO: begin
          // The zero-divisor path spends two cycles so ready rises two edges after acceptance.
          if (cnt_q == 6'd1) begin
            state_q  <= S_END;
            result_q <= 64'd0;
            ready_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 6'd1;
          end
        end
        S_ON: begin
          quo_q <= quoNext_d;
          rem_q <= remNext_d;
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
            state_q  <= S_END;
            result_q <= {remFix_d, quoFix_d};
            ready_q  <= 1'b1;
          end
        end
        S_END: begin
          if (!start_i) begin
            state_q  <= S_FREE;
            result_q <= 64'd0;
            ready_q  <= 1'b0;
          end
        end
        default: begin
          state_q  <= S_FREE;
          result_q <= 64'd0;
          ready_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_div.sv
// tb_ex_div: directed and randomized divisions checked against an arithmetic reference model.
module tb_ex_div;

  logic        clk;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  ex_div dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain arithmetic on the architectural operands.
  function automatic logic [63:0] refDiv(input bit s, input logic [31:0] a, input logic [31:0] b);
    int sa;
    int sb;
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
      sa = a;
      sb = b;
      q  = sa / sb;
      r  = sa % sb;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // One comparison with an immediate assertion.
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Full division handshake: request, latency, result, hold, release.
  task automatic applyStimulus(input bit s, input logic [31:0] a, input logic [31:0] b);
    int lat;
    int expLat;
    logic [63:0] exp;
    string tag;
    tag    = $sformatf("%s %h/%h", s ? "DIV" : "DIVU", a, b);
    exp    = refDiv(s, a, b);
    expLat = (b == 32'd0) ? 2 : 32;
    @(negedge clk);
    signed_div_i = s;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    @(posedge clk);
    #1;
    opdata1_i = $urandom;
    opdata2_i = $urandom | 32'd1;
    signed_div_i = ~s;
    lat = 0;
    while (!ready_o && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput({tag, " latency"}, 64'(lat), 64'(expLat));
    checkOutput({tag, " result"}, result_o, exp);
    @(posedge clk);
    #1;
    checkOutput({tag, " held"}, {63'd0, ready_o} ^ result_o, 64'd1 ^ exp);
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk);
    #1;
    checkOutput({tag, " release"}, {63'd0, ready_o} | result_o, 64'd0);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    bit          rs;
    int          sawReady;

    rst          = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i    = 32'd0;
    opdata2_i    = 32'd0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    #12;
    checkOutput("reset result", result_o, 64'd0);
    checkOutput("reset ready", {63'd0, ready_o}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Directed cases from the test plan.
    applyStimulus(1'b0, 32'd100, 32'd7);
    checkOutput("model 100/7", refDiv(1'b0, 32'd100, 32'd7), 64'h00000002_0000000E);
    applyStimulus(1'b1, 32'hFFFFFFF9, 32'd2);
    applyStimulus(1'b1, 32'd7, 32'hFFFFFFFE);
    applyStimulus(1'b0, 32'hFFFFFFFF, 32'd1);
    applyStimulus(1'b1, 32'h80000000, 32'hFFFFFFFF);
    applyStimulus(1'b0, 32'd5, 32'd9);
    applyStimulus(1'b0, 32'd1234, 32'd0);
    applyStimulus(1'b1, 32'h80000000, 32'd3);

    // Annul on iteration 10: no result, then a fresh division.
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i    = 32'd100;
    opdata2_i    = 32'd7;
    start_i      = 1'b1;
    @(posedge clk);
    repeat (9) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("annul result", {63'd0, ready_o} | result_o, 64'd0);
    @(negedge clk);
    annul_i = 1'b0;
    start_i = 1'b0;
    sawReady = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (ready_o) sawReady = 1;
    end
    checkOutput("annul no ready", 64'(sawReady), 64'd0);
    applyStimulus(1'b0, 32'd100, 32'd7);

    // Start and annul together in FREE: request ignored.
    @(negedge clk);
    opdata2_i = 32'd3;
    start_i   = 1'b1;
    annul_i   = 1'b1;
    @(negedge clk);
    start_i  = 1'b0;
    annul_i  = 1'b0;
    sawReady = 0;
    repeat (36) begin
      @(posedge clk);
      #1;
      if (ready_o) sawReady = 1;
    end
    checkOutput("start+annul ignored", 64'(sawReady), 64'd0);

    // Asynchronous reset mid-ON and while a result is held.
    @(negedge clk);
    opdata1_i = 32'd77;
    opdata2_i = 32'd5;
    start_i   = 1'b1;
    repeat (6) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    checkOutput("reset mid-ON", {63'd0, ready_o} | result_o, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    checkOutput("after reset start held", result_o, refDiv(1'b0, 32'd77, 32'd5));
    #2;
    rst = 1'b0;
    #1;
    checkOutput("reset in END", {63'd0, ready_o} | result_o, 64'd0);
    @(negedge clk);
    start_i = 1'b0;
    rst     = 1'b1;
    applyStimulus(1'b0, 32'd9, 32'd3);

    // Randomized divisions.
    for (int i = 0; i < 24; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1, 2:    rb = $urandom_range(1, 255);
        3:       rb = -($urandom_range(1, 255));
        default: rb = $urandom;
      endcase
      applyStimulus(rs, ra, rb);
    end

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
